// File: rtl/ed25519_sigverify_2.sv
`default_nettype none
// ============================================================================
//  Module      : ed25519_sigverify_2
//  Description : Final Ed25519 verify stage. Inverts Zz by Fermat
//                exponentiation (Zz^(p-2)) on an external fixed-latency
//                modular multiplier, forms affine x/y, and compares the
//                encoded point against the signature's compressed R.
//                i_m packing (MSB..LSB): {Zx, Zy, Zz, Rx, res, sig_l, m}
//                o_m packing (MSB..LSB): {m, sig_l, ok}
//  Revision    : 1.0  initial release
// ============================================================================
module ed25519_sigverify_2 #(
   parameter int MUL_D = 15,
   parameter int M_W   = 16,
   parameter int SL_W  = 256
) (
   input  logic                                  clk,
   input  logic                                  rst,
   output logic                                  i_r,
   input  logic                                  i_v,
   input  logic [3*255+256+1+SL_W+M_W-1:0]       i_m,
   output logic                                  o_v,
   output logic [M_W+SL_W:0]                     o_m,
   output logic                                  mul_o_v,
   output logic [254:0]                          mul_o_a,
   output logic [254:0]                          mul_o_b,
   input  logic                                  mul_i_v,
   input  logic [254:0]                          mul_i_c
);

   // Field offsets inside i_m
   localparam int O_M   = 0;
   localparam int O_SL  = M_W;
   localparam int O_RES = M_W + SL_W;
   localparam int O_RX  = O_RES + 1;
   localparam int O_ZZ  = O_RX + 256;
   localparam int O_ZY  = O_ZZ + 255;
   localparam int O_ZX  = O_ZY + 255;

   localparam int CW = $clog2(MUL_D + 1) + 1;

   // p = 2^255 - 19
   localparam logic [254:0] c_P = ~255'd0 - 255'd18;
   // Low five bits of e = p-2; bits 254..5 are all ones
   localparam logic [7:0]   c_E_LOW = 8'b0000_1011;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SQ    = 3'd1;
   localparam logic [2:0] S_MUL   = 3'd2;
   localparam logic [2:0] S_AFF_Y = 3'd3;
   localparam logic [2:0] S_AFF_X = 3'd4;
   localparam logic [2:0] S_CMP   = 3'd5;
   localparam logic [2:0] S_OUT   = 3'd6;
   localparam logic [2:0] S_DRAIN = 3'd7;

   logic [2:0]      r_state, w_next;
   logic [254:0]    r_zx, r_zy, r_zz, r_acc, r_y, r_x;
   logic [255:0]    r_rx;
   logic            r_res;
   logic [SL_W-1:0] r_sig_l;
   logic [M_W-1:0]  r_m;
   logic [7:0]      r_idx;
   logic            r_busy;
   logic [CW-1:0]   r_cnt;
   logic            r_ok;

   logic            w_op, w_cap, w_ebit, w_x_par;
   logic [254:0]    w_y_c;

   // An op state issues once on entry, then waits for the returning product
   assign w_op   = (r_state == S_SQ) || (r_state == S_MUL) ||
                   (r_state == S_AFF_Y) || (r_state == S_AFF_X);
   assign w_cap  = w_op && r_busy && mul_i_v;
   assign w_ebit = (r_idx >= 8'd5) ? 1'b1 : c_E_LOW[r_idx[2:0]];

   // Single conditional subtract; inputs are < 2^255 so one step suffices.
   // Since p is odd, subtracting p flips the parity of x.
   assign w_y_c   = (r_y >= c_P) ? (r_y - c_P) : r_y;
   assign w_x_par = r_x[0] ^ (r_x >= c_P);

   // State register; reset lands in DRAIN to swallow in-flight products
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_DRAIN;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_v) w_next = S_SQ;
         S_SQ:    if (w_cap) begin
                     if (w_ebit)              w_next = S_MUL;
                     else if (r_idx == 8'd0)  w_next = S_AFF_Y;
                     else                     w_next = S_SQ;
                  end
         S_MUL:   if (w_cap) w_next = (r_idx == 8'd0) ? S_AFF_Y : S_SQ;
         S_AFF_Y: if (w_cap) w_next = S_AFF_X;
         S_AFF_X: if (w_cap) w_next = S_CMP;
         S_CMP:   w_next = S_OUT;
         S_OUT:   w_next = S_IDLE;
         S_DRAIN: if (r_cnt == '0) w_next = S_IDLE;
         default: w_next = S_DRAIN;
      endcase
   end

   // Outputs: ready, result strobe and multiplier issue (operands gated to 0)
   always_comb begin
      i_r     = (r_state == S_IDLE);
      o_v     = (r_state == S_OUT);
      o_m     = '0;
      mul_o_v = w_op && !r_busy;
      mul_o_a = '0;
      mul_o_b = '0;
      if (r_state == S_OUT) o_m = {r_m, r_sig_l, r_ok};
      if (mul_o_v) begin
         case (r_state)
            S_SQ:    begin mul_o_a = r_acc; mul_o_b = r_acc; end
            S_MUL:   begin mul_o_a = r_acc; mul_o_b = r_zz;  end
            S_AFF_Y: begin mul_o_a = r_zy;  mul_o_b = r_acc; end
            S_AFF_X: begin mul_o_a = r_zx;  mul_o_b = r_acc; end
            default: begin mul_o_a = '0;    mul_o_b = '0;    end
         endcase
      end
   end

   // Datapath: item latch, exponent walk, product capture, compare, drain
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_cnt  <= CW'(MUL_D);
         r_ok   <= 1'b0;
      end else begin
         if (r_state == S_IDLE && i_v) begin
            r_zx    <= i_m[O_ZX +: 255];
            r_zy    <= i_m[O_ZY +: 255];
            r_zz    <= i_m[O_ZZ +: 255];
            r_acc   <= i_m[O_ZZ +: 255];
            r_rx    <= i_m[O_RX +: 256];
            r_res   <= i_m[O_RES];
            r_sig_l <= i_m[O_SL +: SL_W];
            r_m     <= i_m[O_M +: M_W];
            r_idx   <= 8'd253;
            r_busy  <= 1'b0;
         end
         if (mul_o_v) r_busy <= 1'b1;
         if (w_cap) begin
            r_busy <= 1'b0;
            case (r_state)
               S_SQ: begin
                  r_acc <= mul_i_c;
                  if (!w_ebit && r_idx != 8'd0) r_idx <= r_idx - 8'd1;
               end
               S_MUL: begin
                  r_acc <= mul_i_c;
                  if (r_idx != 8'd0) r_idx <= r_idx - 8'd1;
               end
               S_AFF_Y: r_y <= mul_i_c;
               S_AFF_X: r_x <= mul_i_c;
               default: ;
            endcase
         end
         if (r_state == S_CMP)
            r_ok <= r_res && (r_zz != '0) && (w_y_c == r_rx[254:0]) &&
                    (w_x_par == r_rx[255]);
         if (r_state == S_DRAIN && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ed25519_sigverify_2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ed25519_sigverify_2
//  Description : Bench for ed25519_sigverify_2 with a behavioural modmul mock
//                and a field-arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ed25519_sigverify_2;
   localparam int MUL_D = 15;
   localparam int M_W   = 16;
   localparam int SL_W  = 256;
   localparam int LAT   = 508 * (MUL_D + 1) + 2;
   localparam logic [254:0] P = ~255'd0 - 255'd18;

   logic clk = 1'b0;
   logic rst, i_r, i_v, o_v, mul_o_v, mul_i_v;
   logic [3*255+256+1+SL_W+M_W-1:0] i_m;
   logic [M_W+SL_W:0] o_m;
   logic [254:0] mul_o_a, mul_o_b, mul_i_c;

   int n_vec = 0, n_bad = 0, cyc = 0, n_iss = 0, n_ov = 0;
   logic nonred = 1'b0;

   logic         sr_v [MUL_D];
   logic [254:0] sr_c [MUL_D];

   ed25519_sigverify_2 #(.MUL_D(MUL_D), .M_W(M_W), .SL_W(SL_W)) dut (
      .clk(clk), .rst(rst), .i_r(i_r), .i_v(i_v), .i_m(i_m),
      .o_v(o_v), .o_m(o_m), .mul_o_v(mul_o_v), .mul_o_a(mul_o_a),
      .mul_o_b(mul_o_b), .mul_i_v(mul_i_v), .mul_i_c(mul_i_c));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [254:0] mmul(input logic [254:0] a, input logic [254:0] b);
      logic [509:0] pr;
      pr = {255'd0, a} * {255'd0, b};
      return 255'(pr % {255'd0, P});
   endfunction

   function automatic logic [254:0] minv(input logic [254:0] z);
      logic [254:0] r, e;
      r = 255'd1;
      e = P - 255'd2;
      for (int i = 254; i >= 0; i--) begin
         r = mmul(r, r);
         if (e[i]) r = mmul(r, z);
      end
      return r;
   endfunction

   function automatic logic ref_ok(input logic [254:0] zx, input logic [254:0] zy,
                                   input logic [254:0] zz, input logic [255:0] rx,
                                   input logic res);
      logic [254:0] inv, x, y;
      if (zz == 255'd0 || !res) return 1'b0;
      inv = minv(zz);
      y = mmul(zy, inv);
      x = mmul(zx, inv);
      return (y == rx[254:0]) && (x[0] == rx[255]);
   endfunction

   // Mock multiplier: product visible exactly MUL_D cycles after issue;
   // optionally returns p+r instead of r when that still fits in 255 bits
   always @(posedge clk) begin
      logic [254:0] r;
      r = mmul(mul_o_a, mul_o_b);
      if (nonred && r < 255'd19) r = r + P;
      sr_v[0] <= mul_o_v;
      sr_c[0] <= r;
      for (int i = 1; i < MUL_D; i++) begin
         sr_v[i] <= sr_v[i-1];
         sr_c[i] <= sr_c[i-1];
      end
   end
   assign mul_i_v = sr_v[MUL_D-1];
   assign mul_i_c = sr_c[MUL_D-1];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: count issues and result strobes, operands must idle at zero
   initial begin
      forever begin
         @(negedge clk);
         if (mul_o_v) n_iss++;
         else if (!rst) chk("mul_operands_idle", 256'(mul_o_a | mul_o_b), 256'd0);
         if (o_v) n_ov++;
      end
   end

   task automatic drain_check(input string tag);
      int n = 0;
      while (!i_r && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk(tag, 256'(n), 256'(MUL_D + 1));
   endtask

   task automatic start_item(input logic [254:0] zx, input logic [254:0] zy,
                             input logic [254:0] zz, input logic [255:0] rx,
                             input logic res, input logic [SL_W-1:0] sig,
                             input logic [M_W-1:0] m, output int t0);
      int g = 0;
      i_m = {zx, zy, zz, rx, res, sig, m};
      i_v = 1'b1;
      while (!i_r && g < 100) begin
         g++;
         @(negedge clk);
      end
      t0 = cyc;
      n_iss = 0;
      @(negedge clk);
      i_v = 1'b0;
      chk("i_r_low_after_accept", 256'(i_r), 256'd0);
   endtask

   task automatic run_item(input string tag, input logic [254:0] zx, input logic [254:0] zy,
                           input logic [254:0] zz, input logic [255:0] rx, input logic res);
      int t0;
      logic exp_ok;
      logic [SL_W-1:0] sig;
      logic [M_W-1:0] m;
      sig = {8{$urandom()}};
      m   = M_W'($urandom());
      exp_ok = ref_ok(zx, zy, zz, rx, res);
      start_item(zx, zy, zz, rx, res, sig, m, t0);
      while (!o_v && (cyc - t0) < LAT + 50) @(negedge clk);
      chk({tag, "_latency"}, 256'(cyc - t0), 256'(LAT));
      chk({tag, "_ok"}, 256'(o_m[0]), 256'(exp_ok));
      chk({tag, "_sig_l"}, 256'(o_m[SL_W:1]), 256'(sig));
      chk({tag, "_m"}, 256'(o_m[SL_W+M_W:SL_W+1]), 256'(m));
      chk({tag, "_issues"}, 256'(n_iss), 256'd508);
      chk({tag, "_i_r_at_o_v"}, 256'(i_r), 256'd0);
      @(negedge clk);
      chk({tag, "_o_v_one_cycle"}, 256'(o_v), 256'd0);
      chk({tag, "_i_r_after"}, 256'(i_r), 256'd1);
   endtask

   initial begin
      logic [254:0] x, y, zz;
      int t0, ov0;
      rst = 1'b1;
      i_v = 1'b0;
      i_m = '0;
      repeat (3) @(negedge clk);
      chk("reset_i_r", 256'(i_r), 256'd0);
      chk("reset_o_v", 256'(o_v), 256'd0);
      chk("reset_mul_o_v", 256'(mul_o_v), 256'd0);
      chk("reset_o_m", 256'(o_m), 256'd0);
      rst = 1'b0;
      drain_check("reset_drain_len");

      run_item("unit_z", 255'd4, 255'd5, 255'd1, {1'b0, 255'd5}, 1'b1);
      run_item("scaled_z", 255'd8, 255'd10, 255'd2, {1'b0, 255'd5}, 1'b1);
      run_item("bad_sign", 255'd8, 255'd10, 255'd2, {1'b1, 255'd5}, 1'b1);
      run_item("zero_z", 255'd4, 255'd5, 255'd0, {1'b0, 255'd5}, 1'b1);
      run_item("res_zero", 255'd4, 255'd5, 255'd1, {1'b0, 255'd5}, 1'b0);
      run_item("noncanon_r", 255'd4, 255'd5, 255'd1, {1'b0, P + 255'd5}, 1'b1);
      nonred = 1'b1;
      run_item("nonreduced", 255'd4, 255'd5, 255'd1, {1'b0, 255'd5}, 1'b1);
      nonred = 1'b0;

      // Reset mid-inversion while a product is still in flight
      ov0 = n_ov;
      start_item(255'd4, 255'd5, 255'd1, {1'b0, 255'd5}, 1'b1, '0, '0, t0);
      while ((cyc - t0) < 3000) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midreset_i_r", 256'(i_r), 256'd0);
      chk("midreset_o_v", 256'(o_v), 256'd0);
      chk("midreset_mul_o_v", 256'(mul_o_v), 256'd0);
      chk("midreset_o_m", 256'(o_m), 256'd0);
      rst = 1'b0;
      drain_check("midreset_drain_len");
      chk("midreset_no_o_v", 256'(n_ov - ov0), 256'd0);

      // Randomised points with random sign agreement and res
      for (int k = 0; k < 2; k++) begin
         y  = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()} >> 2;
         x  = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()} >> 2;
         zz = ({$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()} >> 2) | 255'd1;
         run_item("random", mmul(x, zz), mmul(y, zz), zz,
                  {x[0] ^ ($urandom_range(0, 3) == 0), y}, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ed25519_sigverify_2.md
# ed25519_sigverify_2

Final stage of the Ed25519 verify pipeline. It sits downstream of the DSDP stage's output CDC FIFO and consumes the projective result Z = (Zx:Zy:Zz) plus the carried metadata. It inverts Zz by Fermat exponentiation on a shared external modular multiplier, forms the affine coordinates, and compares the encoded point against the signature's R. It emits a single pass/fail bit together with the message tag.

## Interface
Parameters:
- MUL_D, 15, fixed latency in cycles of the external modmul, from issue to result.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous and active-high.
- i_r  out  1  ready; high only in IDLE after the post-reset drain.
- i_v  in  1  input valid; a transfer occurs on i_v & i_r.
- i_m  in  $bits(sv_meta6_t)  fields used: Zx, Zy, Zz (255 bits each), Rx (256-bit compressed R: [254:0] is y, [255] is the x sign), res, sig_l, m.
- o_v  out  1  one-cycle result strobe; no backpressure.
- o_m  out  $bits(sv_meta7_t)  fields: m, sig_l, ok.
- mul_o_v  out  1  multiply issue strobe.
- mul_o_a  out  255  operand a.
- mul_o_b  out  255  operand b.
- mul_i_v  in  1  result strobe; arrives exactly MUL_D cycles after mul_o_v.
- mul_i_c  in  255  product a*b mod p, with value < 2^255, not necessarily < p.

## Operation
- p = 2^255-19. The exponent e = p-2 has bits 254..5 all 1 and bits 4..0 = 01011.
- On accept, latch Zx, Zy, Zz, Rx, res, sig_l, m. Set acc = Zz and the bit index to 253.
- FSM states are IDLE, SQ, MUL, AFF_Y, AFF_X, CMP, OUT, DRAIN.
- SQ: issue acc*acc, wait for mul_i_v, acc <= mul_i_c. If e[idx]=1, go to MUL; otherwise decrement idx, or go to AFF_Y when idx was 0.
- MUL: issue acc*Zz, wait, acc <= mul_i_c. Then decrement idx, or go to AFF_Y when idx was 0.
- Operation counts are fixed: 254 squarings, 252 multiplies, 506 inversion ops in total.
- AFF_Y: issue Zy*acc and latch y. AFF_X: issue Zx*acc and latch x.
- CMP: canonicalise y and x with one conditional subtract (v >= p gives v-p). Compute ok = res & (Zz != 0) & (y == Rx[254:0]) & (x[0] == Rx[255]).
- Rx[254:0] >= p is never equal to a canonical y, so ok=0 in that case (non-canonical R is rejected).
- OUT: o_v=1 for one cycle; o_m = {m, sig_l, ok}. Next state is IDLE.
- mul_i_v received outside a wait state is ignored.
- Zz=0 yields acc=0 and must still run the full, fixed schedule; it reports ok=0.

## Timing
- Reset values: i_r=0, o_v=0, mul_o_v=0, o_m=0, state=DRAIN with the drain counter at MUL_D.
- DRAIN lasts MUL_D+1 cycles so that in-flight multiplier results are discarded. i_r rises on the first cycle in IDLE.
- Multiply issue: an op issued at cycle t returns at t+MUL_D and is captured at that edge. The next op issues at t+MUL_D+1.
- Each op therefore takes exactly MUL_D+1 cycles. At most one multiply is outstanding.
- Accept at cycle 0: first issue at cycle 1, 508 ops total, o_v at cycle L = 508*(MUL_D+1)+2. With MUL_D=15, L = 8130.
- i_r is low from cycle 1 until the cycle after o_v. Back-to-back items are accepted every L+1 cycles at best.
- mul_o_a and mul_o_b are valid only while mul_o_v=1. They are held at 0 otherwise.
- rst asserted in any state, including mid-inversion: next cycle all outputs are at reset values, state is DRAIN, and the latched item is dropped with no o_v.

## Test plan
- Zz=1, Zy=Rx[254:0]=5, Zx=4, Rx[255]=0, res=1, behavioural mock modmul (MUL_D=15) -> o_v exactly 8130 cycles after accept, ok=1, m and sig_l echoed.
- Same point scaled: Zz=2, Zy=10, Zx=8 -> ok=1. With Rx[255]=1 instead -> ok=0.
- Zz=0, otherwise valid -> o_v at cycle 8130, ok=0. mul_o_v count equals 508.
- res=0 with a matching point -> ok=0. Rx[254:0]=p+5 with y=5 -> ok=0.
- Mock returns y=p+5 (non-reduced) with Rx[254:0]=5 -> ok=1 (conditional subtract exercised).
- rst pulsed at cycle 3000 of an item while the mock still returns its in-flight result -> no o_v for the dropped item, i_r low for 16 cycles, next item completes with correct ok and exact latency.
